// File: rtl/posit_defines.sv
// Shared posit<4,0> constants, quire sizing and stage bundle.
// Imported by the quire-to-posit converter and its encoder.
package posit_defines;

  localparam logic [3:0] POSIT4_NAR    = 4'b1000;
  localparam logic [3:0] POSIT4_ZERO   = 4'b0000;
  localparam logic [3:0] POSIT4_MAXPOS = 4'b0111;
  localparam int         QUIRE_FRAC_BITS = 4;

  function automatic int quire_size(
    input int log_nb_accum
  );
    return 9 + log_nb_accum;
  endfunction

  typedef struct packed {
    logic       nar;
    logic       zero;
    logic       sign;
    logic       sow;
    logic       eow;
    logic       ovf;
    logic [6:0] m;
  } q2p_s1_t;

endpackage

// File: rtl/posit_4_0_round_enc.sv
// Rounds a saturated quire magnitude (1/16 units) to a posit<4,0> code.
// i_m/i_ovf: magnitude and overflow flag; o_code: 3-bit magnitude code.
module posit_4_0_round_enc
  import posit_defines::*;
(
  input  logic [6:0] i_m,
  input  logic       i_ovf,
  output logic [2:0] o_code
);

  logic w_ok;
  assign w_ok = ~i_ovf;

  // Range edges carry the ties-to-even choices; zero magnitude still
  // lands on minpos so a nonzero value never rounds away.
  always_comb begin
    o_code = POSIT4_MAXPOS[2:0];
    unique case (1'b1)
      i_ovf:
        o_code = 3'b111;
      w_ok && (i_m <= 7'd5):
        o_code = 3'b001;
      w_ok && (i_m >= 7'd6) && (i_m <= 7'd10):
        o_code = 3'b010;
      w_ok && (i_m >= 7'd11) && (i_m <= 7'd13):
        o_code = 3'b011;
      w_ok && (i_m >= 7'd14) && (i_m <= 7'd20):
        o_code = 3'b100;
      w_ok && (i_m >= 7'd21) && (i_m <= 7'd27):
        o_code = 3'b101;
      w_ok && (i_m >= 7'd28) && (i_m <= 7'd48):
        o_code = 3'b110;
      w_ok && (i_m >= 7'd49):
        o_code = 3'b111;
      default:
        o_code = 3'b111;
    endcase
  end

endmodule

// File: rtl/quire_to_posit_4_0.sv
// Quire stream to posit<4,0> converter, 2 stages plus 1-entry skid.
// In: rts_i/rtr_o, sow/eow, data/NaR/zero. Out: rts_o/rtr_i, posit.
module quire_to_posit_4_0
  import posit_defines::*;
#(
  parameter int LOG_NB_ACCUM = 10,
  parameter bit EOW_ONLY     = 1'b1,
  localparam int QS = quire_size(LOG_NB_ACCUM)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          rtr_o,
  input  logic          rts_i,
  input  logic          sow_i,
  input  logic          eow_i,
  input  logic [QS-1:0] data_i,
  input  logic          NaR_i,
  input  logic          sign_i,
  input  logic          zero_i,
  input  logic          rtr_i,
  output logic          rts_o,
  output logic          sow_o,
  output logic          eow_o,
  output logic [3:0]    posit_o,
  output logic          NaR_o,
  output logic          zero_o
);

  logic          w_unused;
  logic          w_neg;
  logic [QS:0]   w_ext;
  logic [QS:0]   w_mag;
  q2p_s1_t       w_in;
  logic          w_pen;
  logic          w_xfer;
  logic          w_keep;
  logic          w_sk_v_nxt;
  logic [2:0]    w_code;
  logic [3:0]    w_mag_p;
  logic [3:0]    w_posit;

  logic          r_rtr;
  logic          r_s1_v;
  q2p_s1_t       r_s1;
  logic          r_sk_v;
  q2p_s1_t       r_sk;
  logic          r_rts;
  logic          r_sow;
  logic          r_eow;
  logic [3:0]    r_posit;
  logic          r_nar;
  logic          r_zero;

  // Sign comes from the quire MSB itself.
  assign w_unused = sign_i;

  assign w_neg = data_i[QS-1];
  assign w_ext = {data_i[QS-1], data_i};
  assign w_mag = w_neg ? (~w_ext + 1'b1) : w_ext;

  always_comb begin
    w_in      = '0;
    w_in.nar  = NaR_i;
    w_in.zero = zero_i | (data_i == '0);
    w_in.sign = w_neg;
    w_in.sow  = sow_i;
    w_in.eow  = eow_i;
    w_in.ovf  = |w_mag[QS:7];
    w_in.m    = w_mag[6:0];
  end

  assign w_pen  = rtr_i | ~r_rts;
  assign w_xfer = rts_i & r_rtr;
  assign w_keep = w_xfer & (eow_i | ~EOW_ONLY);

  always_comb begin
    w_sk_v_nxt = r_sk_v;
    if (w_pen)
      w_sk_v_nxt = r_sk_v & w_keep;
    else
      w_sk_v_nxt = r_sk_v | w_keep;
  end

  posit_4_0_round_enc u_enc (
    .i_m   (r_s1.m),
    .i_ovf (r_s1.ovf),
    .o_code(w_code)
  );

  assign w_mag_p = {1'b0, w_code};

  always_comb begin
    w_posit = w_mag_p;
    unique case (1'b1)
      r_s1.nar:
        w_posit = POSIT4_NAR;
      !r_s1.nar && r_s1.zero:
        w_posit = POSIT4_ZERO;
      !r_s1.nar && !r_s1.zero && r_s1.sign:
        w_posit = 4'd0 - w_mag_p;
      default:
        w_posit = w_mag_p;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rtr   <= 1'b0;
      r_s1_v  <= 1'b0;
      r_s1    <= '0;
      r_sk_v  <= 1'b0;
      r_sk    <= '0;
      r_rts   <= 1'b0;
      r_sow   <= 1'b0;
      r_eow   <= 1'b0;
      r_posit <= 4'd0;
      r_nar   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      if (w_pen) begin
        r_rts <= r_s1_v;
        if (r_s1_v) begin
          r_posit <= w_posit;
          r_nar   <= r_s1.nar;
          r_zero  <= ~r_s1.nar & r_s1.zero;
          r_sow   <= EOW_ONLY ? 1'b1 : r_s1.sow;
          r_eow   <= EOW_ONLY ? 1'b1 : r_s1.eow;
        end
        if (r_sk_v) begin
          r_s1_v <= 1'b1;
          r_s1   <= r_sk;
        end else begin
          r_s1_v <= w_keep;
          if (w_keep)
            r_s1 <= w_in;
        end
      end
      if (w_keep && (!w_pen || r_sk_v))
        r_sk <= w_in;
      r_sk_v <= w_sk_v_nxt;
      r_rtr  <= ~w_sk_v_nxt;
    end
  end

  assign rtr_o   = r_rtr;
  assign rts_o   = r_rts;
  assign sow_o   = r_sow;
  assign eow_o   = r_eow;
  assign posit_o = r_posit;
  assign NaR_o   = r_nar;
  assign zero_o  = r_zero;

endmodule

// File: tb/tb_quire_to_posit_4_0.sv
// Directed scoreboard bench for quire_to_posit_4_0.
// Expected posits are pushed on accept and popped on output transfer.
module tb_quire_to_posit_4_0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rtr_o;
  logic        rts_i = 1'b0;
  logic        sow_i = 1'b0;
  logic        eow_i = 1'b0;
  logic [18:0] data_i = '0;
  logic        NaR_i = 1'b0;
  logic        sign_i = 1'b0;
  logic        zero_i = 1'b0;
  logic        rtr_i = 1'b1;
  logic        rts_o;
  logic        sow_o;
  logic        eow_o;
  logic [3:0]  posit_o;
  logic        NaR_o;
  logic        zero_o;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  int n_low   = 0;
  logic [7:0] q[$];
  logic done;

  quire_to_posit_4_0 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rtr_o  (rtr_o),
    .rts_i  (rts_i),
    .sow_i  (sow_i),
    .eow_i  (eow_i),
    .data_i (data_i),
    .NaR_i  (NaR_i),
    .sign_i (sign_i),
    .zero_i (zero_i),
    .rtr_i  (rtr_i),
    .rts_o  (rts_o),
    .sow_o  (sow_o),
    .eow_o  (eow_o),
    .posit_o(posit_o),
    .NaR_o  (NaR_o),
    .zero_o (zero_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ex(input logic [3:0] p);
    return {1'b1, 1'b1, p == 4'b1000, p == 4'b0000, p};
  endfunction

  always @(negedge clk) begin
    if (rst_n && rts_o && rtr_i) begin
      n_out++;
      if (q.size() == 0)
        chk("unexpected_out", {4'd0, posit_o}, 8'hFF);
      else
        chk("out", {sow_o, eow_o, NaR_o, zero_o, posit_o},
            q.pop_front());
    end
  end

  task automatic send(input logic [18:0] d,
                      input logic nar, input logic zr,
                      input logic so, input logic eo,
                      input logic [3:0] p);
    logic rdy;
    logic got;
    got = 1'b0;
    @(negedge clk);
    data_i = d; NaR_i = nar; zero_i = zr;
    sow_i = so; eow_i = eo; sign_i = d[18];
    rts_i = 1'b1;
    for (int k = 0; k < 40; k++) begin
      rdy = rtr_o;
      @(posedge clk);
      if (rdy) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got)
      chk("accept_timeout", 8'd0, 8'd1);
    else if (eo)
      q.push_back(ex(p));
    #1 rts_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !rts_o) break;
    end
    chk(tag, q.size() == 0 ? 8'd0 : 8'd1, 8'd0);
  endtask

  initial begin
    #1;
    chk("rst_rtr", {7'd0, rtr_o}, 8'd0);
    chk("rst_out", {rts_o, sow_o, eow_o, NaR_o, zero_o, 3'd0},
        8'd0);
    chk("rst_posit", {4'd0, posit_o}, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rtr_pre", {7'd0, rtr_o}, 8'd0);
    @(negedge clk);
    chk("rtr_up", {7'd0, rtr_o}, 8'd1);

    send(19'h00010, 0, 0, 1, 1, 4'b0100);
    @(negedge clk);
    chk("lat_s1", {7'd0, rts_o}, 8'd0);
    @(negedge clk);
    chk("lat_s2", {7'd0, rts_o}, 8'd1);
    drain("drain_1p0");

    send(-19'sd24, 0, 0, 1, 1, 4'b1011);
    send(19'd6,    0, 0, 1, 1, 4'b0010);
    send(19'd10,   0, 0, 1, 1, 4'b0010);
    send(19'd48,   0, 0, 1, 1, 4'b0110);
    send(19'd49,   0, 0, 1, 1, 4'b0111);
    send(19'd1,    0, 0, 1, 1, 4'b0001);
    send(19'd5,    0, 0, 1, 1, 4'b0001);
    send(19'd11,   0, 0, 1, 1, 4'b0011);
    send(19'd21,   0, 0, 1, 1, 4'b0101);
    send(19'h3FFFF, 0, 0, 1, 1, 4'b0111);
    send(19'h40000, 0, 0, 1, 1, 4'b1001);
    send(19'd0,    1, 0, 1, 1, 4'b1000);
    send(19'd5,    0, 1, 1, 1, 4'b0000);
    send(19'd0,    0, 0, 1, 1, 4'b0000);
    drain("drain_table");

    n_out = 0;
    send(19'd3,  0, 0, 1, 0, 4'b0000);
    send(19'd40, 0, 0, 0, 0, 4'b0000);
    send(19'd7,  0, 0, 0, 0, 4'b0000);
    send(19'd99, 0, 0, 0, 0, 4'b0000);
    send(19'd16, 0, 0, 0, 1, 4'b0100);
    drain("drain_window");
    chk("window_count", n_out[7:0], 8'd1);

    n_out = 0;
    done = 1'b0;
    fork
      begin
        send(19'd16,   0, 0, 1, 1, 4'b0100);
        send(-19'sd24, 0, 0, 1, 1, 4'b1011);
        send(19'd6,    0, 0, 1, 1, 4'b0010);
        send(19'd49,   0, 0, 1, 1, 4'b0111);
        send(-19'sd16, 0, 0, 1, 1, 4'b1100);
        send(19'd28,   0, 0, 1, 1, 4'b0110);
        send(19'd1,    0, 0, 1, 1, 4'b0001);
        send(19'd14,   0, 0, 1, 1, 4'b0100);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          if (!rtr_o) n_low++;
          #1 rtr_i = ~rtr_i;
        end
      end
    join
    rtr_i = 1'b1;
    drain("drain_burst");
    chk("burst_count", n_out[7:0], 8'd8);
    chk("skid_filled", {7'd0, n_low != 0}, 8'd1);

    rtr_i = 1'b0;
    send(19'd16, 0, 0, 1, 1, 4'b0100);
    send(19'd24, 0, 0, 1, 1, 4'b0101);
    send(19'd32, 0, 0, 1, 1, 4'b0110);
    @(negedge clk);
    chk("full_rtr", {7'd0, rtr_o}, 8'd0);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_out", {rts_o, NaR_o, zero_o, posit_o, rtr_o},
        8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rtr_i = 1'b1;
    n_out = 0;
    repeat (5) @(negedge clk);
    chk("post_rst_quiet", {n_out[3:0], posit_o}, 8'd0);
    chk("post_rst_rtr", {7'd0, rtr_o}, 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
